param_sync_counter: RTL and testbench

- Parametrised synchronous up/down counter. It is the next generation of the team's fixed 4-bit ripple T-flip-flop counter.
- All state bits change on one clock edge. Width and modulus are configurable.
- Adds count enable, direction control, parallel load, terminal-count and wrap flags, and a one-shot (halt-at-terminal) mode.
- Used as the common counter primitive for timers, dividers and sequencers in the design.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_next_calc.sv | 40 ++++
 rtl/param_sync_counter.sv | 97 +++++++++
 tb/tb_param_sync_counter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the synchronous counter primitive.
package counter_pkg;

  localparam logic MODE_FREE_RUN = 1'b0;
  localparam logic MODE_ONE_SHOT = 1'b1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Callers size the argument up with 32'(x) and cast the result back to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational step logic: the value one count away from q in the current
// direction (wrapping at 0 / MODULO-1), terminal detection and the tc flag.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             up_dn_i,
  input  logic             en_i,
  input  logic             halted_i,
  output logic [WIDTH-1:0] q_step_o,
  output logic             at_term_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULO - 1);

  logic at_top;
  logic at_bot;

  assign at_top = (q_i == MAX_V);
  assign at_bot = (q_i == '0);

  always_comb begin
    q_step_o  = q_i;
    at_term_o = 1'b0;
    if (up_dn_i == DIR_UP) begin
      at_term_o = at_top;
      q_step_o  = at_top ? '0 : q_i + WIDTH'(1);
    end else begin
      at_term_o = at_bot;
      q_step_o  = at_bot ? MAX_V : q_i - WIDTH'(1);
    end
  end

  assign tc_o = en_i & ~halted_i & at_term_o;

endmodule

// File: rtl/param_sync_counter.sv
// Parametrised synchronous up/down counter with load, wrap pulse and one-shot halt.
// Define PARAM_SYNC_COUNTER_GRAY_OUT_EN to add the registered q_gray output.
module param_sync_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             halted
`ifdef PARAM_SYNC_COUNTER_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] q_gray
`endif
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULO - 1);
  // One extra bit so MODULO == 2**WIDTH stays representable in the clamp compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             halted_q, halted_d;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] load_clamped;
  logic             at_term;

  counter_next_calc #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_next_calc (
    .q_i       (q_q),
    .up_dn_i   (up_dn),
    .en_i      (en),
    .halted_i  (halted_q),
    .q_step_o  (q_step),
    .at_term_o (at_term),
    .tc_o      (tc)
  );

  assign load_clamped = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_V;

  always_comb begin
    q_d      = q_q;
    wrap_d   = 1'b0;
    halted_d = halted_q;
    if (load) begin
      q_d      = load_clamped;
      halted_d = 1'b0;
    end else if (en && !halted_q) begin
      if (at_term && (mode == MODE_ONE_SHOT)) begin
        halted_d = 1'b1;
        wrap_d   = 1'b1;
      end else begin
        q_d    = q_step;
        wrap_d = at_term;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q      <= '0;
      wrap_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      wrap_q   <= wrap_d;
      halted_q <= halted_d;
    end
  end

  assign q      = q_q;
  assign wrap   = wrap_q;
  assign halted = halted_q;

`ifdef PARAM_SYNC_COUNTER_GRAY_OUT_EN
  logic [WIDTH-1:0] q_gray_q;

  always_ff @(posedge clk) begin
    if (reset) q_gray_q <= '0;
    else       q_gray_q <= WIDTH'(bin2gray(32'(q_d)));
  end

  assign q_gray = q_gray_q;
`endif

endmodule

// File: tb/tb_param_sync_counter.sv
// Scoreboard bench for param_sync_counter (WIDTH=4, MODULO=10); each vector row
// carries the outputs expected to be visible during the cycle it is applied.
module tb_param_sync_counter;
  import counter_pkg::*;

  logic       clk;
  logic       reset, en, up_dn, mode, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, wrap, halted;

  typedef struct {
    bit         chk;
    int         id;
    logic [3:0] q;
    logic       wrap;
    logic       halted;
    logic       tc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   row_id = 0;

`ifdef PARAM_SYNC_COUNTER_GRAY_OUT_EN
  logic [3:0] q_gray;
  logic       g_rst;
  logic [3:0] g_q, g_gray, g_prev;
  logic       g_tc, g_wrap, g_halted;
  bit         g_have = 0;
`endif

  param_sync_counter #(.WIDTH(4), .MODULO(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .halted   (halted)
`ifdef PARAM_SYNC_COUNTER_GRAY_OUT_EN
    ,
    .q_gray   (q_gray)
`endif
  );

`ifdef PARAM_SYNC_COUNTER_GRAY_OUT_EN
  param_sync_counter #(.WIDTH(4), .MODULO(16)) dut_g (
    .clk      (clk),
    .reset    (g_rst),
    .en       (1'b1),
    .up_dn    (1'b1),
    .mode     (1'b0),
    .load     (1'b0),
    .load_val (4'h0),
    .q        (g_q),
    .tc       (g_tc),
    .wrap     (g_wrap),
    .halted   (g_halted),
    .q_gray   (g_gray)
  );

  initial begin
    g_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 g_rst = 1'b0;
  end
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %0h expected %0h", name, id, act, exp);
  endtask

  task automatic row(input logic r, input logic e, input logic u, input logic m,
                     input logic l, input logic [3:0] lv, input bit c,
                     input logic [3:0] eq, input logic ew, input logic eh, input logic et);
    exp_t x;
    @(posedge clk);
    #1;
    reset = r; en = e; up_dn = u; mode = m; load = l; load_val = lv;
    x.chk = c; x.id = row_id; x.q = eq; x.wrap = ew; x.halted = eh; x.tc = et;
    row_id++;
    sb.push_back(x);
  endtask

  // Monitor: mid-cycle, inputs and registered outputs are stable.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        if (x.chk) begin
          check("q",      x.id, 32'(q),      32'(x.q));
          check("wrap",   x.id, 32'(wrap),   32'(x.wrap));
          check("halted", x.id, 32'(halted), 32'(x.halted));
          check("tc",     x.id, 32'(tc),     32'(x.tc));
`ifdef PARAM_SYNC_COUNTER_GRAY_OUT_EN
          if (x.id > 1) check("q_gray", x.id, 32'(q_gray), bin2gray(32'(x.q)));
`endif
        end
      end
`ifdef PARAM_SYNC_COUNTER_GRAY_OUT_EN
      if (!g_rst) begin
        check("g_gray_vs_q", 0, 32'(g_gray), bin2gray(32'(g_q)));
        if (g_have) check("g_one_bit_step", 0, 32'($countones(g_gray ^ g_prev)), 32'd1);
        g_prev = g_gray;
        g_have = 1;
      end
`endif
    end
  end

  initial begin
    int waited;
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; mode = 1'b0; load = 1'b0; load_val = 4'h0;

    // Reset, then free-run up for 12 cycles: 0..9,0,1
    row(1, 0, 1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0);
    row(1, 0, 1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0);
    row(0, 0, 1, 0, 0, 4'h0, 1, 4'h0, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      row(0, 1, 1, 0, 0, 4'h0, 1, 4'(i % 10), (i == 10), 0, (i == 9));

    // Down wrap from a load of 2: 2,1,0,9,8
    row(0, 0, 0, 0, 1, 4'h2, 1, 4'h2, 0, 0, 0);
    row(0, 1, 0, 0, 0, 4'h0, 1, 4'h2, 0, 0, 0);
    row(0, 1, 0, 0, 0, 4'h0, 1, 4'h1, 0, 0, 0);
    row(0, 1, 0, 0, 0, 4'h0, 1, 4'h0, 0, 0, 1);
    row(0, 1, 0, 0, 0, 4'h0, 1, 4'h9, 1, 0, 0);
    row(0, 0, 0, 0, 0, 4'h0, 1, 4'h8, 0, 0, 0);

    // One-shot up from 7: 8,9,9(halted+wrap),9; en and mode change ignored while halted
    row(0, 0, 1, 1, 1, 4'h7, 1, 4'h8, 0, 0, 0);
    row(0, 1, 1, 1, 0, 4'h0, 1, 4'h7, 0, 0, 0);
    row(0, 1, 1, 1, 0, 4'h0, 1, 4'h8, 0, 0, 0);
    row(0, 1, 1, 1, 0, 4'h0, 1, 4'h9, 0, 0, 1);
    row(0, 1, 1, 1, 0, 4'h0, 1, 4'h9, 1, 1, 0);
    row(0, 1, 1, 1, 0, 4'h0, 1, 4'h9, 0, 1, 0);
    row(0, 1, 0, 0, 0, 4'h0, 1, 4'h9, 0, 1, 0);
    row(0, 1, 1, 1, 1, 4'h3, 1, 4'h9, 0, 1, 0);
    row(0, 0, 1, 0, 0, 4'h0, 1, 4'h3, 0, 0, 0);

    // Load clamp (F and 10 both clamp to 9), load beats en, reset beats load
    row(0, 1, 1, 0, 1, 4'hF, 1, 4'h3, 0, 0, 0);
    row(0, 0, 1, 0, 1, 4'hA, 1, 4'h9, 0, 0, 0);
    row(0, 0, 1, 0, 0, 4'h0, 1, 4'h9, 0, 0, 0);
    row(1, 1, 1, 0, 1, 4'h5, 1, 4'h9, 0, 0, 1);
    row(0, 0, 1, 0, 0, 4'h0, 1, 4'h0, 0, 0, 0);

    // Up to 5, flip down, enable gaps, flip back up
    for (int i = 0; i < 5; i++)
      row(0, 1, 1, 0, 0, 4'h0, 1, 4'(i), 0, 0, 0);
    row(0, 1, 0, 0, 0, 4'h0, 1, 4'h5, 0, 0, 0);
    row(0, 0, 0, 0, 0, 4'h0, 1, 4'h4, 0, 0, 0);
    row(0, 1, 0, 0, 0, 4'h0, 1, 4'h4, 0, 0, 0);
    row(0, 0, 0, 0, 0, 4'h0, 1, 4'h3, 0, 0, 0);
    row(0, 1, 0, 0, 0, 4'h0, 1, 4'h3, 0, 0, 0);
    row(0, 0, 0, 0, 0, 4'h0, 1, 4'h2, 0, 0, 0);
    row(0, 1, 1, 0, 0, 4'h0, 1, 4'h2, 0, 0, 0);
    row(0, 0, 1, 0, 0, 4'h0, 1, 4'h3, 0, 0, 0);

    // One-shot down to 0, then reset while halted
    row(0, 0, 0, 1, 1, 4'h1, 1, 4'h3, 0, 0, 0);
    row(0, 1, 0, 1, 0, 4'h0, 1, 4'h1, 0, 0, 0);
    row(0, 1, 0, 1, 0, 4'h0, 1, 4'h0, 0, 0, 1);
    row(0, 1, 0, 1, 0, 4'h0, 1, 4'h0, 1, 1, 0);
    row(1, 1, 0, 1, 0, 4'h0, 1, 4'h0, 0, 1, 0);
    row(0, 0, 0, 1, 0, 4'h0, 1, 4'h0, 0, 0, 0);

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
